sram_arbiter: RTL and testbench

Two-port access controller for the cartridge SRAM: shares the single 21-bit × 8 SRAM between the SNES bus side and the AVR side. Round-robin arbitration, a fixed setup/strobe/hold sequence on `ce_n`/`oe_n`/`we_n`, and a registered read-data return. Sits between the requester front-ends (AVR shift-register/bus logic, SNES decode) and the SRAM pins. Owns all SRAM control strobes and the data-bus output enable.

---
 rtl/sram_arb_pkg.sv | 12 +
 rtl/sram_rr_pick.sv | 21 ++
 rtl/sram_arbiter.sv | 157 +++++++++++++++
 tb/tb_sram_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the cartridge SRAM access controller.
package sram_arb_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} arb_state_e;

  localparam int REQ_SNES = 0;
  localparam int REQ_AVR  = 1;

  localparam int DEF_ADDR_W = 21;
  localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/sram_rr_pick.sv
// Two-way round-robin chooser: on a tie the requester that was not granted last wins.
module sram_rr_pick
  import sram_arb_pkg::*;
(
  input  logic [1:0] eligible,
  input  logic       last_gnt,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  always_comb begin
    gnt_valid = |eligible;
    gnt_idx   = 1'(REQ_SNES);
    if (&eligible) begin
      gnt_idx = ~last_gnt;
    end else if (eligible[REQ_AVR]) begin
      gnt_idx = 1'(REQ_AVR);
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one asynchronous SRAM between the SNES and AVR requesters with
// round-robin arbitration and a registered setup/strobe/hold strobe sequence.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              snes_req,
  input  logic              snes_we,
  input  logic [ADDR_W-1:0] snes_addr,
  input  logic [DATA_W-1:0] snes_wdata,
  output logic              snes_ack,
  output logic [DATA_W-1:0] snes_rdata,
  input  logic              avr_req,
  input  logic              avr_we,
  input  logic [ADDR_W-1:0] avr_addr,
  input  logic [DATA_W-1:0] avr_wdata,
  output logic              avr_ack,
  output logic [DATA_W-1:0] avr_rdata,
  input  logic              avr_excl,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dout,
  input  logic [DATA_W-1:0] sram_din,
  output logic              sram_data_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              busy
);

  localparam int CNT_W = $clog2(WAIT_CYC + 1);

  generate
    if (WAIT_CYC < 1) begin : g_bad_wait
      $error("sram_arbiter: WAIT_CYC must be at least 1");
    end
  endgenerate

  arb_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              side_q, we_q, last_gnt_q;
  logic [1:0]        mask_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] dout_q, snes_rdata_q, avr_rdata_q;
  logic              ce_n_q, oe_n_q, we_n_q, data_oe_q;
  logic              snes_ack_q, avr_ack_q, busy_q;

  logic [1:0]        eligible;
  logic              gnt_valid, gnt_idx;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // The mask keeps a still-high request from being re-granted in the IDLE cycle right after its ack.
  assign eligible[REQ_SNES] = snes_req & ~avr_excl & ~mask_q[REQ_SNES];
  assign eligible[REQ_AVR]  = avr_req & ~mask_q[REQ_AVR];

  sram_rr_pick u_pick (
    .eligible  (eligible),
    .last_gnt  (last_gnt_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign sel_we    = (gnt_idx == 1'(REQ_AVR)) ? avr_we    : snes_we;
  assign sel_addr  = (gnt_idx == 1'(REQ_AVR)) ? avr_addr  : snes_addr;
  assign sel_wdata = (gnt_idx == 1'(REQ_AVR)) ? avr_wdata : snes_wdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      side_q       <= 1'(REQ_SNES);
      we_q         <= 1'b0;
      last_gnt_q   <= 1'(REQ_AVR);
      mask_q       <= '0;
      addr_q       <= '0;
      dout_q       <= '0;
      ce_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      data_oe_q    <= 1'b0;
      snes_ack_q   <= 1'b0;
      avr_ack_q    <= 1'b0;
      snes_rdata_q <= '0;
      avr_rdata_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          mask_q <= '0;
          if (gnt_valid) begin
            state_q    <= SETUP;
            busy_q     <= 1'b1;
            side_q     <= gnt_idx;
            last_gnt_q <= gnt_idx;
            we_q       <= sel_we;
            addr_q     <= sel_addr;
            data_oe_q  <= sel_we;
            ce_n_q     <= 1'b0;
            if (sel_we) dout_q <= sel_wdata;
          end
        end
        SETUP: begin
          state_q <= STROBE;
          cnt_q   <= CNT_W'(WAIT_CYC - 1);
          oe_n_q  <= we_q;
          we_n_q  <= ~we_q;
        end
        STROBE: begin
          // Read data is sampled on the edge that ends the strobe, while oe_n is still low.
          if (cnt_q == '0) begin
            state_q <= HOLD;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            if (side_q == 1'(REQ_AVR)) begin
              avr_ack_q <= 1'b1;
              if (!we_q) avr_rdata_q <= sram_din;
            end else begin
              snes_ack_q <= 1'b1;
              if (!we_q) snes_rdata_q <= sram_din;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        HOLD: begin
          state_q        <= IDLE;
          busy_q         <= 1'b0;
          snes_ack_q     <= 1'b0;
          avr_ack_q      <= 1'b0;
          ce_n_q         <= 1'b1;
          data_oe_q      <= 1'b0;
          mask_q[side_q] <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sram_addr    = addr_q;
  assign sram_dout    = dout_q;
  assign sram_data_oe = data_oe_q;
  assign sram_ce_n    = ce_n_q;
  assign sram_oe_n    = oe_n_q;
  assign sram_we_n    = we_n_q;
  assign snes_ack     = snes_ack_q;
  assign avr_ack      = avr_ack_q;
  assign snes_rdata   = snes_rdata_q;
  assign avr_rdata    = avr_rdata_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed vector table, corner-case sequences and a
// randomized run, all checked cycle by cycle against a transaction-level model.
module tb_sram_arbiter;
  import sram_arb_pkg::*;

  localparam int AW = 21;
  localparam int DW = 8;
  localparam int WC = 2;
  localparam int HOLD_T = WC + 2;
  localparam logic [AW-1:0] SA = 21'h00042;
  localparam logic [AW-1:0] AA = 21'h1ABCD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic snes_req = 1'b0, snes_we = 1'b0, avr_req = 1'b0, avr_we = 1'b0, avr_excl = 1'b0;
  logic [AW-1:0] snes_addr = '0, avr_addr = '0;
  logic [DW-1:0] snes_wdata = '0, avr_wdata = '0, sram_din = '0;
  logic snes_ack, avr_ack, sram_data_oe, sram_ce_n, sram_oe_n, sram_we_n, busy;
  logic [DW-1:0] snes_rdata, avr_rdata, sram_dout;
  logic [AW-1:0] sram_addr;

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(WC)) dut (
    .clk(clk), .rst_n(rst_n),
    .snes_req(snes_req), .snes_we(snes_we), .snes_addr(snes_addr), .snes_wdata(snes_wdata),
    .snes_ack(snes_ack), .snes_rdata(snes_rdata),
    .avr_req(avr_req), .avr_we(avr_we), .avr_addr(avr_addr), .avr_wdata(avr_wdata),
    .avr_ack(avr_ack), .avr_rdata(avr_rdata), .avr_excl(avr_excl),
    .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_din(sram_din),
    .sram_data_oe(sram_data_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  int cycleNo = 0;

  // Reference model: mPhase counts clocks since the grant edge (0 = no access in flight).
  int            mPhase = 0;
  int            mSide = REQ_SNES;
  int            mLast = REQ_AVR;
  bit            mWe = 1'b0;
  logic [AW-1:0] mAddr = '0;
  logic [DW-1:0] mData = '0;
  bit   [1:0]    mMask = '0;
  logic [DW-1:0] mRdata [2];

  typedef struct {
    logic rstN; logic sReq; logic sWe; logic [AW-1:0] sAddr;
    logic aReq; logic aWe; logic [AW-1:0] aAddr; logic [DW-1:0] aWdata; logic [DW-1:0] din;
    logic ceN; logic oeN; logic weN; logic doe; logic sAck; logic aAck; logic bsy;
    logic chkAd; logic [AW-1:0] addr; logic [DW-1:0] dout; logic [DW-1:0] sRd;
  } vec_t;
  vec_t vecs [12];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cycleNo, act, exp);
    end
  endtask

  task automatic modelEdge();
    bit eligS, eligA;
    if (!rst_n) begin
      mPhase = 0; mLast = REQ_AVR; mMask = '0; mRdata[0] = '0; mRdata[1] = '0;
    end else if (mPhase == 0) begin
      eligS = snes_req && !avr_excl && !mMask[REQ_SNES];
      eligA = avr_req && !mMask[REQ_AVR];
      mMask = '0;
      if (eligS || eligA) begin
        if (eligS && eligA) mSide = (mLast == REQ_SNES) ? REQ_AVR : REQ_SNES;
        else                mSide = eligS ? REQ_SNES : REQ_AVR;
        mLast = mSide;
        mPhase = 1;
        if (mSide == REQ_SNES) begin mWe = snes_we; mAddr = snes_addr; mData = snes_wdata; end
        else                   begin mWe = avr_we;  mAddr = avr_addr;  mData = avr_wdata;  end
      end
    end else if (mPhase == HOLD_T) begin
      mMask[mSide] = 1'b1;
      mPhase = 0;
    end else begin
      if (mPhase == WC + 1 && !mWe) mRdata[mSide] = sram_din;
      mPhase++;
    end
  endtask

  task automatic compareModel();
    bit strobe;
    strobe = (mPhase >= 2) && (mPhase <= WC + 1);
    checkOutput("ce_n", sram_ce_n, mPhase == 0);
    checkOutput("oe_n", sram_oe_n, !(strobe && !mWe));
    checkOutput("we_n", sram_we_n, !(strobe && mWe));
    checkOutput("data_oe", sram_data_oe, (mPhase != 0) && mWe);
    checkOutput("snes_ack", snes_ack, (mPhase == HOLD_T) && (mSide == REQ_SNES));
    checkOutput("avr_ack", avr_ack, (mPhase == HOLD_T) && (mSide == REQ_AVR));
    checkOutput("busy", busy, mPhase != 0);
    checkOutput("snes_rdata", snes_rdata, mRdata[0]);
    checkOutput("avr_rdata", avr_rdata, mRdata[1]);
    if (!rst_n) begin
      checkOutput("reset sram_addr", sram_addr, 0);
      checkOutput("reset sram_dout", sram_dout, 0);
    end else if (mPhase != 0) begin
      checkOutput("sram_addr", sram_addr, mAddr);
      if (mWe) checkOutput("sram_dout", sram_dout, mData);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    modelEdge();
    cycleNo++;
    #1;
    compareModel();
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    rst_n = v.rstN; snes_req = v.sReq; snes_we = v.sWe; snes_addr = v.sAddr;
    avr_req = v.aReq; avr_we = v.aWe; avr_addr = v.aAddr; avr_wdata = v.aWdata; sram_din = v.din;
    stepCycle();
    checkOutput($sformatf("vec%0d ce_n", idx), sram_ce_n, v.ceN);
    checkOutput($sformatf("vec%0d oe_n", idx), sram_oe_n, v.oeN);
    checkOutput($sformatf("vec%0d we_n", idx), sram_we_n, v.weN);
    checkOutput($sformatf("vec%0d data_oe", idx), sram_data_oe, v.doe);
    checkOutput($sformatf("vec%0d snes_ack", idx), snes_ack, v.sAck);
    checkOutput($sformatf("vec%0d avr_ack", idx), avr_ack, v.aAck);
    checkOutput($sformatf("vec%0d busy", idx), busy, v.bsy);
    checkOutput($sformatf("vec%0d snes_rdata", idx), snes_rdata, v.sRd);
    if (v.chkAd) begin
      checkOutput($sformatf("vec%0d sram_addr", idx), sram_addr, v.addr);
      checkOutput($sformatf("vec%0d sram_dout", idx), sram_dout, v.dout);
    end
  endtask

  // Safety net so a stuck run still ends with a visible failure.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ackSide[$];
    int ackCyc[$];
    int cnt;
    bit seen;
    mRdata[0] = '0; mRdata[1] = '0;

    // Reset with both requesting, then SNES read (wins first tie), then the pending AVR write.
    vecs[0]  = '{1'b0,1'b1,1'b0,SA, 1'b1,1'b1,AA,8'h5A,8'h00, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,21'h0,8'h00,8'h00};
    vecs[1]  = vecs[0];
    vecs[2]  = '{1'b1,1'b1,1'b0,SA, 1'b1,1'b1,AA,8'h5A,8'h00, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1, 1'b1,SA,8'h00,8'h00};
    vecs[3]  = '{1'b1,1'b1,1'b0,SA, 1'b1,1'b1,AA,8'h5A,8'hC3, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1, 1'b1,SA,8'h00,8'h00};
    vecs[4]  = vecs[3];
    vecs[5]  = '{1'b1,1'b1,1'b0,SA, 1'b1,1'b1,AA,8'h5A,8'hC3, 1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,1'b1, 1'b1,SA,8'h00,8'hC3};
    vecs[6]  = '{1'b1,1'b0,1'b0,SA, 1'b1,1'b1,AA,8'h5A,8'h00, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,21'h0,8'h00,8'hC3};
    vecs[7]  = '{1'b1,1'b0,1'b0,SA, 1'b1,1'b1,AA,8'h5A,8'h00, 1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b1, 1'b1,AA,8'h5A,8'hC3};
    vecs[8]  = '{1'b1,1'b0,1'b0,SA, 1'b1,1'b1,AA,8'h5A,8'h00, 1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b1, 1'b1,AA,8'h5A,8'hC3};
    vecs[9]  = vecs[8];
    vecs[10] = '{1'b1,1'b0,1'b0,SA, 1'b1,1'b1,AA,8'h5A,8'h00, 1'b0,1'b1,1'b1,1'b1,1'b0,1'b1,1'b1, 1'b1,AA,8'h5A,8'hC3};
    vecs[11] = '{1'b1,1'b0,1'b0,SA, 1'b0,1'b1,AA,8'h5A,8'h00, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,21'h0,8'h00,8'hC3};

    #2;
    for (int i = 0; i < 12; i++) applyStimulus(vecs[i], i);

    // Contention: both requests held high must alternate SNES/AVR, one access every WC+3 clocks.
    snes_req = 1'b1; snes_we = 1'b1; snes_addr = 21'h0F00D; snes_wdata = 8'hA7;
    avr_req = 1'b1; avr_we = 1'b0; avr_addr = 21'h12345;
    for (int k = 0; k < 60 && ackSide.size() < 4; k++) begin
      sram_din = DW'($urandom);
      stepCycle();
      if (snes_ack) begin ackSide.push_back(REQ_SNES); ackCyc.push_back(cycleNo); end
      if (avr_ack)  begin ackSide.push_back(REQ_AVR);  ackCyc.push_back(cycleNo); end
    end
    checkOutput("contention ack count", ackSide.size(), 4);
    for (int k = 0; k < ackSide.size(); k++) begin
      checkOutput($sformatf("contention order %0d", k), ackSide[k], (k % 2 == 0) ? REQ_SNES : REQ_AVR);
      if (k > 0) checkOutput($sformatf("contention gap %0d", k), ackCyc[k] - ackCyc[k-1], WC + 3);
    end
    snes_req = 1'b0; avr_req = 1'b0;
    repeat (HOLD_T + 2) stepCycle();

    // Exclusive mode raised mid-SNES-access: that access still completes.
    snes_req = 1'b1; snes_we = 1'b0; snes_addr = 21'h00777; sram_din = 8'h3C;
    stepCycle();
    avr_excl = 1'b1; avr_req = 1'b1; avr_we = 1'b1; avr_addr = 21'h1F00F; avr_wdata = 8'h99;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin stepCycle(); seen = snes_ack; end
    checkOutput("excl in-flight snes ack", seen, 1);
    seen = 1'b0; cnt = 0;
    for (int k = 0; k < 20 && !seen; k++) begin stepCycle(); seen = avr_ack; cnt += int'(snes_ack); end
    checkOutput("excl avr served", seen, 1);
    avr_req = 1'b0;
    repeat (8) begin stepCycle(); cnt += int'(snes_ack) + int'(busy); end
    checkOutput("excl snes held off", cnt, 0);
    avr_excl = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin stepCycle(); seen = snes_ack; end
    checkOutput("snes granted after excl drop", seen, 1);
    snes_req = 1'b0;
    repeat (HOLD_T + 2) stepCycle();

    // Reset in the middle of a write strobe: abandoned without an ack.
    avr_req = 1'b1; avr_we = 1'b1; avr_addr = 21'h0ABCD; avr_wdata = 8'hE1;
    for (int k = 0; k < 10 && mPhase != 2; k++) stepCycle();
    checkOutput("mid-strobe we_n low", sram_we_n, 0);
    rst_n = 1'b0;
    stepCycle();
    checkOutput("reset abort ce_n", sram_ce_n, 1);
    checkOutput("reset abort we_n", sram_we_n, 1);
    checkOutput("reset abort data_oe", sram_data_oe, 0);
    rst_n = 1'b1; avr_req = 1'b0;
    cnt = 0;
    repeat (10) begin stepCycle(); cnt += int'(avr_ack); end
    checkOutput("no ack for aborted write", cnt, 0);

    // Randomized traffic with occasional exclusive toggles and resets.
    for (int c = 0; c < 1500; c++) begin
      sram_din = DW'($urandom);
      rst_n = ($urandom_range(299) != 0);
      if ($urandom_range(15) == 0) avr_excl = ~avr_excl;
      if (mPhase == HOLD_T && mSide == REQ_SNES) begin
        snes_req = ($urandom_range(2) == 0);
        snes_we = 1'($urandom); snes_addr = AW'($urandom); snes_wdata = DW'($urandom);
      end else if (!snes_req && $urandom_range(3) == 0) begin
        snes_req = 1'b1; snes_we = 1'($urandom); snes_addr = AW'($urandom); snes_wdata = DW'($urandom);
      end else if (mPhase != 0 && mPhase < HOLD_T && mSide == REQ_SNES && $urandom_range(1) == 1) begin
        snes_we = 1'($urandom); snes_addr = AW'($urandom); snes_wdata = DW'($urandom);
      end
      if (mPhase == HOLD_T && mSide == REQ_AVR) begin
        avr_req = ($urandom_range(2) == 0);
        avr_we = 1'($urandom); avr_addr = AW'($urandom); avr_wdata = DW'($urandom);
      end else if (!avr_req && $urandom_range(3) == 0) begin
        avr_req = 1'b1; avr_we = 1'($urandom); avr_addr = AW'($urandom); avr_wdata = DW'($urandom);
      end else if (mPhase != 0 && mPhase < HOLD_T && mSide == REQ_AVR && $urandom_range(1) == 1) begin
        avr_we = 1'($urandom); avr_addr = AW'($urandom); avr_wdata = DW'($urandom);
      end
      stepCycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
